// File: rtl/crg_pkg.sv
// rtl/crg_pkg.sv - shared clock/reset types for the reset sequencer
package crg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_GAP,
    ST_DONE
  } rst_seq_state_e;

  // Counter must reach the larger of the two intervals without wrapping.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    int m;
    m = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rtl/rst_seq_timer.sv - clearable saturating up-counter with terminal-count compare
module rst_seq_timer #(
  parameter int CW = 5
) (
  input  logic          ref_clk_i,
  input  logic          glob_arst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] tc_i,
  output logic          tc_hit_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_hit_o = (cnt_q == tc_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - ordered release of per-domain reset requests after a hold period
module rst_seq_ctrl
  import crg_pkg::*;
#(
  parameter int NUM_DOM  = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 4
) (
  input  logic                     ref_clk_i,
  input  logic                     glob_arst_ni,
  input  logic                     sw_rst_req_i,
  output logic [NUM_DOM-1:0]       arst_req_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(NUM_DOM):0] rel_idx_o
);

  localparam int IW = $clog2(NUM_DOM) + 1;
  localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_TC  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOM - 1);

  rst_seq_state_e     state_q, state_d;
  logic [NUM_DOM-1:0] arst_q, arst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IW-1:0]      rel_q, rel_d;

  logic          tmr_clr, tmr_en, tmr_hit;
  logic [CW-1:0] tmr_tc;

  rst_seq_timer #(.CW(CW)) u_timer (
    .ref_clk_i    (ref_clk_i),
    .glob_arst_ni (glob_arst_ni),
    .clr_i        (tmr_clr),
    .en_i         (tmr_en),
    .tc_i         (tmr_tc),
    .tc_hit_o     (tmr_hit)
  );

  always_comb begin
    state_d = state_q;
    arst_d  = arst_q;
    rel_d   = rel_q;
    done_d  = (state_q == ST_DONE);
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tmr_tc  = (state_q == ST_GAP) ? GAP_TC : HOLD_TC;

    case (state_q)
      ST_IDLE: begin
        arst_d = '0;
        if (sw_rst_req_i) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!sw_rst_req_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        tmr_en = 1'b1;
        if (tmr_hit) begin
          state_d = ST_RELEASE;
          tmr_clr = 1'b1;
        end
      end
      ST_RELEASE: begin
        for (int i = 0; i < NUM_DOM; i++) begin
          if (rel_q == IW'(i)) arst_d[i] = 1'b0;
        end
        rel_d = rel_q + IW'(1);
        if (rel_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else if (GAP_CYC == 0) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_hit) begin
          state_d = ST_RELEASE;
          tmr_clr = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sw_rst_req_i && (state_q inside {ST_HOLD, ST_RELEASE, ST_GAP, ST_DONE})) begin
      state_d = ST_ASSERT;
    end

    // Entering or sitting in ASSERT re-arms every domain on that same edge.
    if ((state_d == ST_ASSERT) || (state_q == ST_ASSERT)) begin
      arst_d  = '1;
      rel_d   = '0;
      tmr_clr = 1'b1;
      tmr_en  = 1'b0;
    end

    busy_d = !((state_q == ST_IDLE) && (state_d == ST_IDLE));
  end

  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      state_q <= ST_HOLD;
      arst_q  <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      arst_q  <= arst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rel_q   <= rel_d;
    end
  end

  assign arst_req_o = arst_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rel_idx_o  = rel_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

  localparam int NUM    = 4;
  localparam int HOLD   = 16;
  localparam int GAP    = 4;
  localparam int T_LAST = HOLD + 1 + (NUM - 1) * (GAP + 1);

  logic       ref_clk_i = 1'b0;
  logic       glob_arst_ni = 1'b1;
  logic       sw_rst_req_i = 1'b0;
  logic       sw0 = 1'b0;
  logic [3:0] arst_req_o, arst0;
  logic       busy_o, done_o, busy0, done0;
  logic [2:0] rel_idx_o, rel0;

  always #5 ref_clk_i = ~ref_clk_i;

  rst_seq_ctrl #(.NUM_DOM(NUM), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .ref_clk_i    (ref_clk_i),
    .glob_arst_ni (glob_arst_ni),
    .sw_rst_req_i (sw_rst_req_i),
    .arst_req_o   (arst_req_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rel_idx_o    (rel_idx_o)
  );

  rst_seq_ctrl #(.NUM_DOM(NUM), .HOLD_CYC(HOLD), .GAP_CYC(0)) dut_gap0 (
    .ref_clk_i    (ref_clk_i),
    .glob_arst_ni (glob_arst_ni),
    .sw_rst_req_i (sw0),
    .arst_req_o   (arst0),
    .busy_o       (busy0),
    .done_o       (done0),
    .rel_idx_o    (rel0)
  );

  typedef struct {
    int         edge_n;
    logic       gap0;
    logic [3:0] arst;
    logic       busy;
    logic       done;
    logic [2:0] rel;
  } vec_t;

  vec_t vecs[15];

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // Reference model: time since the sequence started decides everything.
  int         m_mode;
  int         m_t;
  logic [3:0] e_arst;
  logic       e_busy, e_done;
  logic [2:0] e_rel;

  function automatic int rel_time(input int i);
    return HOLD + 1 + i * (GAP + 1);
  endfunction

  task automatic model_reset();
    m_mode = 2;
    m_t    = 0;
    e_arst = 4'hF;
    e_busy = 1'b1;
    e_done = 1'b0;
    e_rel  = 3'd0;
  endtask

  task automatic model_ones();
    e_arst = 4'hF;
    e_busy = 1'b1;
    e_rel  = 3'd0;
  endtask

  task automatic model_edge(input logic sw);
    int released;
    e_done = 1'b0;
    if (m_mode == 2) begin
      m_t++;
      if (m_t > T_LAST + 1) m_mode = 0;
    end
    case (m_mode)
      0: begin
        if (sw) begin
          m_mode = 1;
          model_ones();
        end else begin
          e_arst = 4'h0;
          e_busy = 1'b0;
        end
      end
      1: begin
        model_ones();
        if (!sw) begin
          m_mode = 2;
          m_t    = 0;
        end
      end
      default: begin
        if (sw) begin
          e_done = (m_t == T_LAST + 1);
          m_mode = 1;
          model_ones();
        end else begin
          released = 0;
          for (int i = 0; i < NUM; i++) begin
            e_arst[i] = (m_t < rel_time(i));
            if (m_t >= rel_time(i)) released++;
          end
          e_rel  = 3'(released);
          e_busy = 1'b1;
          e_done = (m_t == T_LAST + 1);
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (arst,busy,done,rel)", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic sw, input string tag);
    sw_rst_req_i = sw;
    @(posedge ref_clk_i);
    model_edge(sw);
    @(negedge ref_clk_i);
    if (done_o) done_cnt++;
    chk(tag, {arst_req_o, busy_o, done_o, rel_idx_o}, {e_arst, e_busy, e_done, e_rel});
  endtask

  initial begin
    int held_bad;
    vecs[0]  = '{16, 1'b0, 4'b1111, 1'b1, 1'b0, 3'd0};
    vecs[1]  = '{17, 1'b0, 4'b1110, 1'b1, 1'b0, 3'd1};
    vecs[2]  = '{21, 1'b0, 4'b1110, 1'b1, 1'b0, 3'd1};
    vecs[3]  = '{22, 1'b0, 4'b1100, 1'b1, 1'b0, 3'd2};
    vecs[4]  = '{27, 1'b0, 4'b1000, 1'b1, 1'b0, 3'd3};
    vecs[5]  = '{32, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd4};
    vecs[6]  = '{33, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd4};
    vecs[7]  = '{34, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd4};
    vecs[8]  = '{16, 1'b1, 4'b1111, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{17, 1'b1, 4'b1110, 1'b1, 1'b0, 3'd1};
    vecs[10] = '{18, 1'b1, 4'b1100, 1'b1, 1'b0, 3'd2};
    vecs[11] = '{19, 1'b1, 4'b1000, 1'b1, 1'b0, 3'd3};
    vecs[12] = '{20, 1'b1, 4'b0000, 1'b1, 1'b0, 3'd4};
    vecs[13] = '{21, 1'b1, 4'b0000, 1'b1, 1'b1, 3'd4};
    vecs[14] = '{22, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd4};

    // Power-on
    #1 glob_arst_ni = 1'b0;
    #19;
    chk("por_in_reset", {arst_req_o, busy_o, done_o, rel_idx_o}, {4'hF, 1'b1, 1'b0, 3'd0});
    chk("por_in_reset_gap0", {arst0, busy0, done0, rel0}, {4'hF, 1'b1, 1'b0, 3'd0});
    #10 glob_arst_ni = 1'b1;
    model_reset();
    done_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      cycle(1'b0, "por_model");
      for (int v = 0; v < 15; v++) begin
        if (vecs[v].edge_n == e) begin
          if (vecs[v].gap0)
            chk($sformatf("por_gap0_edge%0d", e), {arst0, busy0, done0, rel0},
                {vecs[v].arst, vecs[v].busy, vecs[v].done, vecs[v].rel});
          else
            chk($sformatf("por_edge%0d", e), {arst_req_o, busy_o, done_o, rel_idx_o},
                {vecs[v].arst, vecs[v].busy, vecs[v].done, vecs[v].rel});
        end
      end
    end
    chk_int("por_done_pulses", done_cnt, 1);

    // Software request from IDLE
    done_cnt = 0;
    cycle(1'b1, "sw_req");
    chk("sw_req_assert", {arst_req_o, busy_o, done_o, rel_idx_o}, {4'hF, 1'b1, 1'b0, 3'd0});
    repeat (40) cycle(1'b0, "sw_seq");
    chk_int("sw_done_pulses", done_cnt, 1);

    // Restart in GAP after bit1 released
    done_cnt = 0;
    cycle(1'b1, "rs_req");
    repeat (24) cycle(1'b0, "rs_pre");
    chk_int("rs_in_gap_rel", int'(rel_idx_o), 2);
    cycle(1'b1, "rs_restart");
    chk("rs_reassert", {arst_req_o, busy_o, done_o, rel_idx_o}, {4'hF, 1'b1, 1'b0, 3'd0});
    repeat (40) cycle(1'b0, "rs_seq");
    chk_int("rs_done_pulses", done_cnt, 1);

    // Held request
    done_cnt = 0;
    held_bad = 0;
    repeat (100) begin
      cycle(1'b1, "held");
      if (arst_req_o !== 4'hF) held_bad++;
    end
    chk_int("held_no_release", held_bad, 0);
    repeat (40) cycle(1'b0, "held_after");
    chk_int("held_done_pulses", done_cnt, 1);

    // Restart coinciding with DONE
    done_cnt = 0;
    cycle(1'b1, "dr_req");
    cycle(1'b0, "dr_t0");
    repeat (T_LAST) cycle(1'b0, "dr_run");
    cycle(1'b1, "dr_restart");
    chk("dr_done_and_assert", {arst_req_o, busy_o, done_o, rel_idx_o}, {4'hF, 1'b1, 1'b1, 3'd0});
    repeat (40) cycle(1'b0, "dr_seq");
    chk_int("dr_done_pulses", done_cnt, 2);

    // Mid-sequence global reset during HOLD
    done_cnt = 0;
    cycle(1'b1, "gr_req");
    repeat (6) cycle(1'b0, "gr_hold");
    #2 glob_arst_ni = 1'b0;
    #1;
    chk("gr_async", {arst_req_o, busy_o, done_o, rel_idx_o}, {4'hF, 1'b1, 1'b0, 3'd0});
    model_reset();
    @(posedge ref_clk_i);
    @(negedge ref_clk_i);
    chk("gr_held", {arst_req_o, busy_o, done_o, rel_idx_o}, {4'hF, 1'b1, 1'b0, 3'd0});
    chk_int("gr_no_done", done_cnt, 0);
    glob_arst_ni = 1'b1;
    repeat (40) cycle(1'b0, "gr_rerun");
    chk_int("gr_done_pulses", done_cnt, 1);

    // Random requests against the model
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOM, default 4: number of sequenced reset domains (range 1-16).
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles all domains are held in reset (≥1).
REQ-003 SHALL have parameter GAP_CYC, default 4: idle cycles between consecutive domain releases (≥0).
REQ-004 ref_clk_i  input  1  reference clock; all logic on rising edge.
REQ-005 glob_arst_ni  input  1  global reset; asynchronous, active-low.
REQ-006 sw_rst_req_i  input  1  software reset request; level sampled each rising edge.
REQ-007 arst_req_o  output  NUM_DOM  per-domain reset request; bit i drives arst_req_i of domain i's arst_no instance.
REQ-008 busy_o  output  1  high while a reset sequence is in progress.
REQ-009 done_o  output  1  one-cycle pulse on sequence completion.
REQ-010 rel_idx_o  output  $clog2(NUM_DOM)+1  index of the next domain to release; NUM_DOM when all are released.

Function
REQ-011 FSM states SHALL be IDLE, ASSERT, HOLD, RELEASE, GAP, DONE; all outputs registered.
REQ-012 IDLE: arst_req_o=0, busy_o=0; sw_rst_req_i=1 -> ASSERT.
REQ-013 ASSERT (1 cycle): arst_req_o set to all ones, counter cleared, rel_idx_o=0 -> HOLD.
REQ-014 HOLD: counter increments each cycle; on counter==HOLD_CYC-1 -> RELEASE, counter cleared.
REQ-015 RELEASE (1 cycle): arst_req_o[rel_idx_o] cleared and rel_idx_o incremented; rel_idx_o==NUM_DOM-1 -> DONE; else GAP_CYC==0 -> RELEASE; else -> GAP.
REQ-016 GAP: counter increments; on counter==GAP_CYC-1 -> RELEASE, counter cleared.
REQ-017 Domains SHALL release strictly in ascending index order, one per RELEASE visit.
REQ-018 DONE (1 cycle): done_o=1 -> IDLE.
REQ-019 busy_o SHALL be 1 in every state except IDLE.
REQ-020 sw_rst_req_i=1 in HOLD, RELEASE, GAP or DONE SHALL force ASSERT on the next edge (restart); all domains re-assert, counter and rel_idx_o clear.
REQ-021 If DONE and restart coincide, done_o SHALL still pulse in that cycle.
REQ-022 A held-high sw_rst_req_i SHALL keep the FSM cycling through ASSERT, so no domain releases until the request drops.
REQ-023 Counter width SHALL be $clog2(max(HOLD_CYC,GAP_CYC)+1); the counter SHALL never wrap.

Reset
REQ-024 glob_arst_ni low SHALL immediately force arst_req_o to all ones, busy_o=1, done_o=0, rel_idx_o=0, counter=0, and state HOLD.
REQ-025 On glob_arst_ni deassertion, the power-on release sequence SHALL run automatically from HOLD, with no software request.
REQ-026 glob_arst_ni assertion mid-sequence SHALL abort the sequence with no done_o pulse.

Structure
REQ-027 State enum rst_seq_state_e SHALL reside in shared package crg_pkg.
REQ-028 Counting SHALL use one sub-module, rst_seq_timer: a clearable up-counter with a terminal-count compare input.
REQ-029 rst_seq_ctrl SHALL instantiate no arst_no; the integrator connects arst_req_o to the domain instances.

Verification (NUM_DOM=4, HOLD_CYC=16, GAP_CYC=4, 10 ns clock)
REQ-030 Power-on check: glob_arst_ni low for 30 ns, then high -> arst_req_o=4'b1111 during reset; bit0 falls 17 edges after deassert; bits 1-3 fall every 5 edges (at 22, 27, 32); done_o pulses at edge 33; busy_o falls at edge 34.
REQ-031 Software request: from IDLE, one-cycle sw_rst_req_i -> arst_req_o=4'b1111 one edge later; same release spacing as the power-on check; exactly one done_o pulse.
REQ-032 Restart: sw_rst_req_i pulsed in GAP after bit1 releases -> arst_req_o back to 4'b1111 next edge; full sequence reruns; one done_o only.
REQ-033 Held request: sw_rst_req_i high for 100 cycles -> arst_req_o stays 4'b1111 throughout; the sequence completes 33 edges after the request drops.
REQ-034 Mid-sequence global reset: glob_arst_ni pulsed low during HOLD -> arst_req_o=4'b1111 asynchronously, no done_o; sequence reruns from HOLD.
REQ-035 GAP_CYC=0 build: releases occur on consecutive edges, and rel_idx_o steps 0,1,2,3,4.
